// File: rtl/md_scheduler_pkg.sv
// Shared opcode and state encodings for the multiply/divide scheduler.
package md_scheduler_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  function automatic logic md_is_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide producing the pending HI/LO pair.
module md_arith
  import md_scheduler_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] pend_hi,
  output logic [31:0] pend_lo,
  output logic        pend_wr
);

  logic [63:0]        ext_a;
  logic [63:0]        ext_b;
  logic [63:0]        prod;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;

  always_comb begin
    ext_a   = '0;
    ext_b   = '0;
    prod    = '0;
    sa      = $signed(a);
    sb      = $signed(b);
    sq      = '0;
    sr      = '0;
    pend_hi = '0;
    pend_lo = '0;
    pend_wr = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: begin
        // Extending both operands to 64 bits makes the low 64 product bits exact for either signedness.
        ext_a   = (op == MD_MULT) ? {{32{a[31]}}, a} : {32'h0, a};
        ext_b   = (op == MD_MULT) ? {{32{b[31]}}, b} : {32'h0, b};
        prod    = ext_a * ext_b;
        pend_hi = prod[63:32];
        pend_lo = prod[31:0];
        pend_wr = 1'b1;
      end
      MD_DIV: begin
        if (b != '0) begin
          pend_wr = 1'b1;
          if (a == 32'h8000_0000 && b == '1) begin
            pend_lo = 32'h8000_0000;
            pend_hi = '0;
          end else begin
            sq      = sa / sb;
            sr      = sa % sb;
            pend_lo = sq;
            pend_hi = sr;
          end
        end
      end
      MD_DIVU: begin
        if (b != '0) begin
          pend_wr = 1'b1;
          pend_lo = a / b;
          pend_hi = a % b;
        end
      end
      default: pend_wr = 1'b0;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: fixed-latency occupancy of the MD unit, HI/LO ownership and stall request.
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ex_md_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        ex_rd_hi,
  input  logic        id_md_use,
  output logic [31:0] md_out,
  output logic        busy,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic [31:0] arith_hi;
  logic [31:0] arith_lo;
  logic        arith_wr;

  md_arith u_arith (
    .a       (ex_a),
    .b       (ex_b),
    .op      (ex_md_op),
    .pend_hi (arith_hi),
    .pend_lo (arith_lo),
    .pend_wr (arith_wr)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (md_is_start(ex_md_op)) begin
          pend_hi_d = arith_hi;
          pend_lo_d = arith_lo;
          pend_wr_d = arith_wr;
          cnt_d     = md_is_div(ex_md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d   = S_BUSY;
        end else if (ex_md_op == MD_MTHI) begin
          hi_d = ex_a;
        end else if (ex_md_op == MD_MTLO) begin
          lo_d = ex_a;
        end
      end
      S_BUSY: begin
        // Any opcode arriving here is ignored; md_stall keeps legal code from reaching it.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign md_out   = ex_rd_hi ? hi_q : lo_q;
  assign busy     = (state_q == S_BUSY);
  assign md_stall = id_md_use & (busy | md_is_start(ex_md_op));

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: a timestamp-based reference model queues expected outputs per cycle.
module tb_md_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                         OP_DIVU = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ex_md_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_rd_hi;
  logic        id_md_use;
  logic [31:0] md_out;
  logic        busy;
  logic        md_stall;

  always #5 clk = ~clk;

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_md_op  (ex_md_op),
    .ex_a      (ex_a),
    .ex_b      (ex_b),
    .ex_rd_hi  (ex_rd_hi),
    .id_md_use (id_md_use),
    .md_out    (md_out),
    .busy      (busy),
    .md_stall  (md_stall)
  );

  typedef struct {
    logic [31:0] out;
    logic        busy;
    logic        stall;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: architectural HI/LO, pending result, and the edge number at which it lands.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 1'b0;
  longint      edge_no = 0;
  longint      done_at = 0;

  function automatic bit m_busy();
    return edge_no < done_at;
  endfunction

  function automatic bit is_start(input logic [3:0] op);
    return op >= OP_MULT && op <= OP_DIVU;
  endfunction

  function automatic void ref_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p_wr = 1'b1;
    case (op)
      OP_MULT:  begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; end
      OP_MULTU: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; end
      OP_DIV: begin
        if (b == 32'h0) p_wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
      end
      default: begin
        if (b == 32'h0) p_wr = 1'b0;
        else begin up = ua / ub; p_lo = up[31:0]; up = ua % ub; p_hi = up[31:0]; end
      end
    endcase
  endfunction

  task automatic do_cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic rd_hi, input logic use_id, input logic rst_n);
    bit was_busy;
    ex_md_op  = op;
    ex_a      = a;
    ex_b      = b;
    ex_rd_hi  = rd_hi;
    id_md_use = use_id;
    reset     = rst_n;
    if (!rst_n) begin
      m_hi    = '0;
      m_lo    = '0;
      done_at = edge_no;
    end
    sb_q.push_back('{out: (rd_hi ? m_hi : m_lo), busy: m_busy(),
                     stall: use_id && (m_busy() || is_start(op))});
    was_busy = m_busy();
    @(posedge clk);
    edge_no++;
    if (rst_n) begin
      if (was_busy) begin
        if (edge_no == done_at && p_wr) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end else if (is_start(op)) begin
        ref_compute(op, a, b);
        done_at = edge_no + ((op == OP_DIV || op == OP_DIVU) ? DC : MC);
      end else if (op == OP_MTHI) begin
        m_hi = a;
      end else if (op == OP_MTLO) begin
        m_lo = a;
      end
    end else begin
      done_at = edge_no;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic use_id);
    for (int i = 0; i < n; i++) do_cycle(OP_NONE, $urandom, $urandom, i[0], use_id, 1'b1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("md_out", md_out, e.out);
      chk("busy", {31'h0, busy}, {31'h0, e.busy});
      chk("md_stall", {31'h0, md_stall}, {31'h0, e.stall});
    end
  end

  initial begin
    logic [3:0] op;
    reset     = 1'b0;
    ex_md_op  = OP_NONE;
    ex_a      = '0;
    ex_b      = '0;
    ex_rd_hi  = 1'b0;
    id_md_use = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) do_cycle(OP_NONE, '0, '0, i[0], 1'b0, 1'b0);

    do_cycle(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 1'b1);
    idle(MC + 2, 1'b0);
    do_cycle(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b1);
    idle(MC + 2, 1'b0);
    do_cycle(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b1);
    idle(DC + 2, 1'b1);
    do_cycle(OP_MTHI, 32'h11, '0, 1'b0, 1'b0, 1'b1);
    do_cycle(OP_MTLO, 32'h22, '0, 1'b1, 1'b0, 1'b1);
    do_cycle(OP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(DC + 2, 1'b0);
    do_cycle(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    idle(DC + 2, 1'b1);
    do_cycle(OP_MTHI, 32'hDEAD_BEEF, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    do_cycle(OP_MULT, 32'd7, 32'd9, 1'b0, 1'b0, 1'b1);
    do_cycle(OP_MTLO, 32'hCAFE_0000, '0, 1'b0, 1'b0, 1'b1);
    do_cycle(OP_DIV, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    idle(MC, 1'b0);

    do_cycle(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(OP_NONE, '0, '0, i[0], 1'b0, 1'b0);
    idle(MC + 3, 1'b0);

    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 11))
        0, 1:    op = OP_MULT;
        2:       op = OP_MULTU;
        3:       op = OP_DIV;
        4:       op = OP_DIVU;
        5:       op = OP_MTHI;
        6:       op = OP_MTLO;
        7:       op = 4'($urandom_range(7, 15));
        default: op = OP_NONE;
      endcase
      do_cycle(op, pick_val(), pick_val(), 1'($urandom), 1'($urandom), ($urandom_range(0, 99) != 0));
    end
    idle(DC + 2, 1'b0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Multiply/divide scheduler for the 5-stage pipeline. Accepts mult/multu/div/divu and mthi/mtlo from the EX stage, occupies the shared multiply/divide resource for a fixed latency, and owns the HI/LO registers. Drives a stall request that the hazard controller ORs into the pipeline stall, so MD-class instructions cannot enter EX while the unit is busy.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10: busy cycles for div/divu (≥1)
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low; clears all state
- ex_md_op  in  4  EX-stage MD opcode: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; other codes behave as NONE
- ex_a  in  32  forwarded rs value in EX
- ex_b  in  32  forwarded rt value in EX
- ex_rd_hi  in  1  md_out select: 1=HI, 0=LO (mfhi/mflo)
- id_md_use  in  1  ID-stage instruction is any MD-class (mult..divu, mthi, mtlo, mfhi, mflo)
- md_out  out  32  combinational HI or LO per ex_rd_hi
- busy  out  1  operation in flight
- md_stall  out  1  stall request to hazard controller

## Operation
- States: IDLE, BUSY. Down-counter cnt holds remaining cycles.
- IDLE, ex_md_op ∈ {MULT, MULTU, DIV, DIVU}: capture the result into internal pend_hi/pend_lo at the clock edge, load cnt with MULT_CYCLES or DIV_CYCLES, go to BUSY.
- BUSY: cnt decrements each edge; on the edge where cnt goes 1→0, HI←pend_hi, LO←pend_lo, return to IDLE.
- MULT: {HI,LO} = signed 64-bit a×b. MULTU: unsigned. DIV: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend. DIVU: unsigned.
- Divide by zero: occupies full DIV_CYCLES; HI/LO unchanged at completion.
- Signed overflow (0x80000000 / −1): LO=0x80000000, HI=0.
- MTHI/MTLO in IDLE: write HI or LO with ex_a at the edge, no busy.
- Start or MTHI/MTLO arriving while BUSY: ignored, no state change (illegal; prevented by md_stall).
- md_stall = id_md_use & (busy | ex_md_op ∈ {MULT..DIVU}).
- md_out is combinational from HI/LO registers only; never exposes pend values.

## Timing
- Reset values: HI=0, LO=0, busy=0, md_stall=0 (with id_md_use=0), state IDLE, cnt=0, md_out=0.
- Start sampled at edge E0; busy=1 from E0 through E_N where N = MULT_CYCLES or DIV_CYCLES; HI/LO updated and busy=0 at E_N. mfhi in ID is stalled for cycles E0−1 … E_N−1 and reads the new value in EX after E_N.
- Back-to-back: a second mult waiting in ID issues to EX at E_N; it starts at E_{N+1}.
- MTHI/MTLO: HI/LO visible on md_out the cycle after the edge.
- Reset asserted mid-operation: aborts immediately (async), pend results discarded, HI/LO=0.
- Reset deasserted: first start accepted at the next rising edge.

## Structure
- Opcode constants MD_NONE..MD_MTLO go in name.v alongside the existing instruction and Level defines; the controller emits ex_md_op from EXIR.
- One combinational sub-module md_arith (a, b, op → pend_hi, pend_lo) isolates signed/unsigned arithmetic; state, counter and HI/LO stay in md_scheduler.
- md_stall is consumed by Hcontroller, which ORs it into Stalk.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; md_out unchanged until completion edge.
- MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles; DIV a=−7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles.
- DIVU a=100, b=0 with prior HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO remain 0x11/0x22.
- id_md_use=1 (mflo) during a DIV -> md_stall high every cycle until the completion edge, low the cycle after; with id_md_use=0 md_stall stays 0 throughout.
- MTHI a=0xDEADBEEF in IDLE -> HI=0xDEADBEEF next cycle, busy stays 0; MTLO issued while BUSY -> LO unchanged.
- Reset pulsed low 3 cycles into a MULT -> busy, HI, LO go 0 immediately; no completion write occurs after release.
